// File: rtl/mips_ctrl_pkg.sv
// Shared definitions for the MIPS fetch-stage control logic.
package mips_ctrl_pkg;

  typedef enum logic [1:0] {
    BOOT    = 2'd0,
    FETCH   = 2'd1,
    MEMWAIT = 2'd2
  } state_e;

  localparam int unsigned PC_STEP  = 4;
  localparam logic [31:0] RESET_PC = 32'h0000_0000;

endpackage

// File: rtl/sat_counter.sv
// Saturating up-counter with asynchronous active-high clear.
module sat_counter #(
  parameter int unsigned WIDTH = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             inc,
  output logic [WIDTH-1:0] count
);

  logic [WIDTH-1:0] count_q;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      count_q <= '0;
    end else if (inc && (count_q != '1)) begin
      count_q <= count_q + 1'b1;
    end
  end

  assign count = count_q;

endmodule

// File: rtl/pc_sequencer.sv
// Program-counter sequencer for the fetch stage: arbitrates memory wait, load-use stall,
// branch and jump redirects, and counts non-advancing cycles.
module pc_sequencer #(
  parameter int unsigned PC_WIDTH  = 32,
  parameter int unsigned PC_STEP   = 4,
  parameter int unsigned CNT_WIDTH = 16
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic [PC_WIDTH-1:0]  pc_current,
  input  logic                 imem_ready,
  input  logic                 hazard_stall,
  input  logic                 branch_taken,
  input  logic [PC_WIDTH-1:0]  branch_target,
  input  logic                 jump,
  input  logic [PC_WIDTH-1:0]  jump_target,
  output logic                 pc_write,
  output logic [PC_WIDTH-1:0]  pc_next,
  output logic                 imem_req,
  output logic                 if_id_write,
  output logic                 if_id_flush,
  output logic [CNT_WIDTH-1:0] stall_count
);

  import mips_ctrl_pkg::*;

  state_e              state_q, state_d;
  logic                pending_valid_q, pending_valid_d;
  logic [PC_WIDTH-1:0] pending_target_q, pending_target_d;
  logic [PC_WIDTH-1:0] next_raw;
  logic                redirect;
  logic [PC_WIDTH-1:0] redirect_target;
  logic                count_inc;

  // Branch is the older instruction, so it wins over a jump in the same cycle.
  assign redirect        = branch_taken | jump;
  assign redirect_target = branch_taken ? branch_target : jump_target;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q          <= BOOT;
      pending_valid_q  <= 1'b0;
      pending_target_q <= PC_WIDTH'(RESET_PC);
    end else begin
      state_q          <= state_d;
      pending_valid_q  <= pending_valid_d;
      pending_target_q <= pending_target_d;
    end
  end

  always_comb begin
    state_d          = state_q;
    pending_valid_d  = pending_valid_q;
    pending_target_d = pending_target_q;
    pc_write         = 1'b0;
    next_raw         = '0;
    imem_req         = 1'b0;
    if_id_write      = 1'b0;
    if_id_flush      = 1'b0;
    unique case (state_q)
      BOOT: state_d = FETCH;
      FETCH: begin
        imem_req = 1'b1;
        if (redirect) begin
          pc_write    = 1'b1;
          next_raw    = redirect_target;
          if_id_flush = 1'b1;
        end else if (!imem_ready) begin
          state_d = MEMWAIT;
        end else if (!hazard_stall) begin
          pc_write    = 1'b1;
          next_raw    = pc_current + PC_WIDTH'(PC_STEP);
          if_id_write = 1'b1;
        end
      end
      MEMWAIT: begin
        imem_req = 1'b1;
        if (!imem_ready) begin
          // Redirect is remembered until the outstanding fetch returns.
          if (redirect) begin
            pending_valid_d  = 1'b1;
            pending_target_d = redirect_target;
            if_id_flush      = 1'b1;
          end
        end else begin
          if (redirect) begin
            pc_write    = 1'b1;
            next_raw    = redirect_target;
            if_id_flush = 1'b1;
          end else if (pending_valid_q) begin
            pc_write    = 1'b1;
            next_raw    = pending_target_q;
            if_id_flush = 1'b1;
          end
          pending_valid_d = 1'b0;
          state_d         = FETCH;
        end
      end
      default: state_d = BOOT;
    endcase
  end

  assign pc_next   = {next_raw[PC_WIDTH-1:2], 2'b00};
  assign count_inc = ((state_q == FETCH) || (state_q == MEMWAIT)) && !pc_write;

  sat_counter #(
    .WIDTH (CNT_WIDTH)
  ) u_stall_counter (
    .clk   (clk),
    .reset (reset),
    .inc   (count_inc),
    .count (stall_count)
  );

endmodule

// File: tb/tb_pc_sequencer.sv
// Scoreboard bench for pc_sequencer: driver pushes model expectations, monitor pops and compares.
module tb_pc_sequencer;

  localparam int unsigned CW      = 16;
  localparam int unsigned CNT_MAX = (1 << CW) - 1;

  logic          clk = 1'b0;
  logic          reset = 1'b1;
  logic [31:0]   pc_current = '0;
  logic          imem_ready = 1'b0;
  logic          hazard_stall = 1'b0;
  logic          branch_taken = 1'b0;
  logic [31:0]   branch_target = '0;
  logic          jump = 1'b0;
  logic [31:0]   jump_target = '0;
  logic          pc_write;
  logic [31:0]   pc_next;
  logic          imem_req;
  logic          if_id_write;
  logic          if_id_flush;
  logic [CW-1:0] stall_count;

  pc_sequencer #(
    .PC_WIDTH  (32),
    .PC_STEP   (4),
    .CNT_WIDTH (CW)
  ) dut (
    .clk           (clk),
    .reset         (reset),
    .pc_current    (pc_current),
    .imem_ready    (imem_ready),
    .hazard_stall  (hazard_stall),
    .branch_taken  (branch_taken),
    .branch_target (branch_target),
    .jump          (jump),
    .jump_target   (jump_target),
    .pc_write      (pc_write),
    .pc_next       (pc_next),
    .imem_req      (imem_req),
    .if_id_write   (if_id_write),
    .if_id_flush   (if_id_flush),
    .stall_count   (stall_count)
  );

  always #5 clk = ~clk;

  typedef struct {
    bit          pc_write;
    logic [31:0] pc_next;
    bit          imem_req;
    bit          if_id_write;
    bit          if_id_flush;
    int unsigned stall_count;
  } exp_t;

  exp_t sb_q[$];
  int   n_checks = 0;
  int   n_err    = 0;
  bit   drive_done = 1'b0;

  // Reference model: plain flags for boot/waiting and a queue for the pending redirect.
  bit          m_boot = 1'b1;
  bit          m_waiting = 1'b0;
  logic [31:0] m_pending[$];
  logic [31:0] m_pc = '0;
  int unsigned m_cnt = 0;

  function automatic logic [31:0] align(input logic [31:0] v);
    return v & 32'hFFFF_FFFC;
  endfunction

  task automatic step(input bit rst, input bit rdy, input bit haz, input bit br,
                      input logic [31:0] bt, input bit jp, input logic [31:0] jt);
    exp_t        e;
    bit          redir;
    logic [31:0] tgt;
    @(posedge clk);
    #1;
    if (rst) begin
      m_boot = 1'b1;
      m_waiting = 1'b0;
      m_pending.delete();
      m_pc = '0;
      m_cnt = 0;
    end
    reset = rst;
    imem_ready = rdy;
    hazard_stall = haz;
    branch_taken = br;
    branch_target = bt;
    jump = jp;
    jump_target = jt;
    pc_current = m_pc;
    e = '{pc_write: 1'b0, pc_next: 32'h0, imem_req: 1'b0, if_id_write: 1'b0,
          if_id_flush: 1'b0, stall_count: m_cnt};
    redir = br || jp;
    tgt   = br ? bt : jt;
    if (rst) begin
      // everything zero
    end else if (m_boot) begin
      m_boot = 1'b0;
    end else begin
      e.imem_req = 1'b1;
      if (!m_waiting) begin
        if (redir) begin
          e.pc_write = 1'b1;
          e.pc_next = align(tgt);
          e.if_id_flush = 1'b1;
        end else if (!rdy) begin
          m_waiting = 1'b1;
        end else if (!haz) begin
          e.pc_write = 1'b1;
          e.pc_next = align(m_pc + 32'd4);
          e.if_id_write = 1'b1;
        end
      end else if (!rdy) begin
        if (redir) begin
          m_pending.delete();
          m_pending.push_back(tgt);
          e.if_id_flush = 1'b1;
        end
      end else begin
        if (redir) begin
          e.pc_write = 1'b1;
          e.pc_next = align(tgt);
          e.if_id_flush = 1'b1;
        end else if (m_pending.size() > 0) begin
          e.pc_write = 1'b1;
          e.pc_next = align(m_pending[0]);
          e.if_id_flush = 1'b1;
        end
        m_pending.delete();
        m_waiting = 1'b0;
      end
      if (!e.pc_write && m_cnt < CNT_MAX) m_cnt++;
      if (e.pc_write) m_pc = e.pc_next;
    end
    sb_q.push_back(e);
  endtask

  task automatic run(input bit rdy, input bit haz);
    step(1'b0, rdy, haz, 1'b0, 32'h0, 1'b0, 32'h0);
  endtask

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s at %0t: got %h, expected %h", nm, $time, act, exp);
    end
  endtask

  // Monitor: combinational outputs are sampled mid-cycle, half a period after the driver.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (sb_q.size() > 0) begin
        e = sb_q.pop_front();
        chk("pc_write", 32'(pc_write), 32'(e.pc_write));
        chk("pc_next", pc_next, e.pc_next);
        chk("imem_req", 32'(imem_req), 32'(e.imem_req));
        chk("if_id_write", 32'(if_id_write), 32'(e.if_id_write));
        chk("if_id_flush", 32'(if_id_flush), 32'(e.if_id_flush));
        chk("stall_count", 32'(stall_count), e.stall_count);
      end
    end
  end

  initial begin
    #5_000_000;
    $display("FAIL watchdog: stimulus did not complete");
    $fatal(1, "timeout");
  end

  initial begin
    // Reset, boot, then sequential fetch 4, 8, C.
    step(1'b1, 1'b1, 1'b0, 1'b0, 32'h0, 1'b0, 32'h0);
    step(1'b1, 1'b1, 1'b0, 1'b0, 32'h0, 1'b0, 32'h0);
    repeat (4) run(1'b1, 1'b0);
    // Load-use stall at 0x100.
    m_pc = 32'h100;
    repeat (2) run(1'b1, 1'b1);
    run(1'b1, 1'b0);
    // Branch and jump together under a hazard.
    step(1'b0, 1'b1, 1'b1, 1'b1, 32'h200, 1'b1, 32'h300);
    // Memory wait with a jump on the first waiting cycle.
    run(1'b0, 1'b0);
    step(1'b0, 1'b0, 1'b0, 1'b0, 32'h0, 1'b1, 32'h40);
    repeat (2) run(1'b0, 1'b0);
    run(1'b1, 1'b0);
    run(1'b1, 1'b0);
    // Wrap and unaligned target.
    m_pc = 32'hFFFF_FFFC;
    run(1'b1, 1'b0);
    step(1'b0, 1'b1, 1'b0, 1'b1, 32'h203, 1'b0, 32'h0);
    // Later redirect overwrites the pending one; hazard ignored while waiting.
    run(1'b0, 1'b1);
    step(1'b0, 1'b0, 1'b1, 1'b0, 32'h0, 1'b1, 32'h500);
    step(1'b0, 1'b0, 1'b0, 1'b1, 32'h600, 1'b0, 32'h0);
    run(1'b1, 1'b1);
    // Randomized traffic.
    for (int i = 0; i < 400; i++) begin
      step(1'b0, $urandom_range(0, 3) != 0, $urandom_range(0, 3) == 0,
           $urandom_range(0, 7) == 0, $urandom, $urandom_range(0, 7) == 0, $urandom);
    end
    // Long stall drives the counter into saturation.
    run(1'b1, 1'b0);
    for (int i = 0; i < 65540; i++) run(1'b1, 1'b1);
    run(1'b1, 1'b1);
    // Reset while a redirect is pending in the wait state.
    run(1'b0, 1'b0);
    step(1'b0, 1'b0, 1'b0, 1'b0, 32'h0, 1'b1, 32'h7000);
    step(1'b1, 1'b0, 1'b0, 1'b0, 32'h0, 1'b0, 32'h0);
    step(1'b1, 1'b1, 1'b0, 1'b0, 32'h0, 1'b0, 32'h0);
    repeat (4) run(1'b1, 1'b0);
    drive_done = 1'b1;
  end

  initial begin
    wait (drive_done);
    repeat (3) @(posedge clk);
    n_checks++;
    if (sb_q.size() != 0) begin
      n_err++;
      $display("FAIL scoreboard_drain: %0d entries left, expected 0", sb_q.size());
    end
    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule
